press_emitter: RTL and testbench
================================

PRESS_EMITTER -- requirements
Module: press_emitter

Interface
REQ-001 Parameter BOUNCE_STEP, default 3, cycles per bounce level; SHALL be 1..15.
REQ-002 Parameter BOUNCE_EDGES, default 4, bounce levels per transition; SHALL be even and >= 2.
REQ-003 Parameter HOLD_CYCLES, default 40, stable-high cycles per press; SHALL be >= 20.
REQ-004 Parameter GAP_CYCLES, default 40, stable-low cycles after each release; SHALL be >= 20.
REQ-005 clk_12m  in  1  clock; all logic SHALL run on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  request a burst; sampled only in IDLE.
REQ-008 abort  in  1  terminate the burst in progress.
REQ-009 press_total  in  16  number of presses to emit; latched when start is accepted.
REQ-010 busy  out  1  high in every state except IDLE and DONE.
REQ-011 done  out  1  one-cycle pulse when a burst completes normally.
REQ-012 btn_out  out  1  emulated raw, bouncy button line.
REQ-013 presses_sent  out  16  presses fully emitted in the current or last burst.

Function
REQ-014 The FSM SHALL have the states IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP and DONE.
REQ-015 btn_out SHALL be registered; in IDLE, GAP and DONE it SHALL be 0, and in HOLD it SHALL be 1.
REQ-016 IDLE with start=1 and abort=0: latch press_total and clear presses_sent; next state PRESS_BOUNCE, or DONE if press_total=0.
REQ-017 PRESS_BOUNCE: BOUNCE_EDGES levels, each BOUNCE_STEP cycles, alternating 1,0,1,0,...; then HOLD.
REQ-018 HOLD: HOLD_CYCLES cycles; then RELEASE_BOUNCE.
REQ-019 RELEASE_BOUNCE: BOUNCE_EDGES levels, each BOUNCE_STEP cycles, alternating 0,1,0,1,...; then GAP, incrementing presses_sent on that transition.
REQ-020 GAP: GAP_CYCLES cycles; then DONE if presses_sent equals the latched total, else PRESS_BOUNCE.
REQ-021 DONE: exactly one cycle with done=1; then IDLE.
REQ-022 Per-press period SHALL be P = 2*BOUNCE_EDGES*BOUNCE_STEP + HOLD_CYCLES + GAP_CYCLES cycles (104 at defaults).
REQ-023 Timing: start sampled in cycle 0 -> btn_out=1 in cycle 1 -> done=1 in cycle N*P+1 (N = latched total).
REQ-024 start SHALL be ignored while busy or in DONE; press_total changes after the latch SHALL have no effect.
REQ-025 abort=1 in any busy state SHALL, on the next cycle, enter IDLE with btn_out=0 and no done pulse; presses_sent holds.
REQ-026 start and abort both high in IDLE: abort SHALL win and the start is dropped.
REQ-027 presses_sent SHALL hold its value in IDLE until the next accepted start; press_total=16'hFFFF SHALL complete without wrap.
REQ-028 A single phase down-counter of at least 8 bits SHALL time every state; it reloads on each state or level change.

Reset
REQ-029 rst=1 SHALL force IDLE, btn_out=0, busy=0, done=0, presses_sent=0, latched total=0 and phase counter=0.
REQ-030 rst SHALL override start and abort; asserting rst mid-burst SHALL terminate the burst with no done pulse.

Structure
REQ-031 The state enum and default timing constants SHALL live in the shared package super_counter_pkg.
REQ-032 The block SHALL be a single module with one clocked process and no sub-modules.

Verification
REQ-033 press_total=3, start pulse at cycle 0 -> done only at cycle 313; presses_sent=3; btn_out shows 3 bursts of 2 bounce pulses plus a 40-cycle high.
REQ-034 press_total=0 with start -> done at cycle 1; busy never high; btn_out stays 0.
REQ-035 press_total=5, abort at cycle 250 -> IDLE at cycle 251, btn_out=0, presses_sent=2, no done.
REQ-036 Second start during a burst of 2 -> ignored; exactly 2 presses and one done at cycle 209.
REQ-037 Loop btn_out into the team's 16-cycle debounced press counter with press_total=7 -> counter reads exactly 7 with no bounce-induced counts.
REQ-038 rst at cycle 150 of a 4-press burst -> all outputs at reset values next cycle; a new start works normally.

Source files
------------

// File: rtl/super_counter_pkg.sv
// Shared definitions for the super counter slice: emitter FSM states and
// default timing of the emulated button.
package super_counter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS_BOUNCE,
      ST_HOLD,
      ST_RELEASE_BOUNCE,
      ST_GAP,
      ST_DONE
   } emit_state_t;

   localparam int DEF_BOUNCE_STEP  = 3;
   localparam int DEF_BOUNCE_EDGES = 4;
   localparam int DEF_HOLD_CYCLES  = 40;
   localparam int DEF_GAP_CYCLES   = 40;

   // Wide enough for any sensible hold/gap length, not just the defaults.
   localparam int PHASE_W = 16;
   localparam int LEVEL_W = 8;

endpackage

// File: rtl/press_emitter.sv
// Emits a burst of bouncy button presses on btn_out, for exercising the
// debounced press counter. One phase down-counter times every state/level.
module press_emitter
   import super_counter_pkg::*;
#(
   parameter int BOUNCE_STEP  = DEF_BOUNCE_STEP,
   parameter int BOUNCE_EDGES = DEF_BOUNCE_EDGES,
   parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
   input  logic        clk_12m,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] press_total,
   output logic        busy,
   output logic        done,
   output logic        btn_out,
   output logic [15:0] presses_sent
);

   localparam logic [PHASE_W-1:0] C_STEP_LD  = PHASE_W'(BOUNCE_STEP - 1);
   localparam logic [PHASE_W-1:0] C_HOLD_LD  = PHASE_W'(HOLD_CYCLES - 1);
   localparam logic [PHASE_W-1:0] C_GAP_LD   = PHASE_W'(GAP_CYCLES - 1);
   localparam logic [LEVEL_W-1:0] C_LAST_LVL = LEVEL_W'(BOUNCE_EDGES - 1);

   emit_state_t        r_state;
   logic [PHASE_W-1:0] r_phase_cnt;
   logic [LEVEL_W-1:0] r_level;
   logic [15:0]        r_total;
   logic [15:0]        r_sent;
   logic               r_btn;

   emit_state_t        w_state_nxt;
   logic [PHASE_W-1:0] w_cnt_nxt;
   logic [LEVEL_W-1:0] w_level_nxt;
   logic [15:0]        w_total_nxt;
   logic [15:0]        w_sent_nxt;
   logic               w_btn_nxt;
   logic               w_seg_end;
   logic               w_busy;

   assign w_seg_end = (r_phase_cnt == '0);
   assign w_busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_phase_cnt;
      w_level_nxt = r_level;
      w_total_nxt = r_total;
      w_sent_nxt  = r_sent;
      w_btn_nxt   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               w_total_nxt = press_total;
               w_sent_nxt  = '0;
               w_level_nxt = '0;
               if (press_total == '0) begin
                  w_state_nxt = ST_DONE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = ST_PRESS_BOUNCE;
                  w_cnt_nxt   = C_STEP_LD;
               end
            end
         end
         ST_PRESS_BOUNCE, ST_RELEASE_BOUNCE: begin
            if (!w_seg_end) begin
               w_cnt_nxt = r_phase_cnt - 1'b1;
            end else if (r_level != C_LAST_LVL) begin
               w_level_nxt = r_level + 1'b1;
               w_cnt_nxt   = C_STEP_LD;
            end else if (r_state == ST_PRESS_BOUNCE) begin
               w_state_nxt = ST_HOLD;
               w_level_nxt = '0;
               w_cnt_nxt   = C_HOLD_LD;
            end else begin
               w_state_nxt = ST_GAP;
               w_level_nxt = '0;
               w_cnt_nxt   = C_GAP_LD;
               w_sent_nxt  = r_sent + 1'b1;
            end
         end
         ST_HOLD: begin
            if (!w_seg_end) begin
               w_cnt_nxt = r_phase_cnt - 1'b1;
            end else begin
               w_state_nxt = ST_RELEASE_BOUNCE;
               w_level_nxt = '0;
               w_cnt_nxt   = C_STEP_LD;
            end
         end
         ST_GAP: begin
            if (!w_seg_end) begin
               w_cnt_nxt = r_phase_cnt - 1'b1;
            end else if (r_sent == r_total) begin
               w_state_nxt = ST_DONE;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = ST_PRESS_BOUNCE;
               w_level_nxt = '0;
               w_cnt_nxt   = C_STEP_LD;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_level_nxt = '0;
         end
      endcase

      // Abort drops the burst outright; a press finishing this cycle is not counted.
      if (abort && w_busy) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_level_nxt = '0;
         w_sent_nxt  = r_sent;
      end

      // The line level follows the state being entered so btn_out is registered.
      case (w_state_nxt)
         ST_PRESS_BOUNCE:   w_btn_nxt = ~w_level_nxt[0];
         ST_HOLD:           w_btn_nxt = 1'b1;
         ST_RELEASE_BOUNCE: w_btn_nxt = w_level_nxt[0];
         default:           w_btn_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk_12m) begin
      // NOTE: state registers use non-blocking assignments only.
      if (rst) begin
         r_state     <= ST_IDLE;
         r_phase_cnt <= '0;
         r_level     <= '0;
         r_total     <= '0;
         r_sent      <= '0;
         r_btn       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_phase_cnt <= w_cnt_nxt;
         r_level     <= w_level_nxt;
         r_total     <= w_total_nxt;
         r_sent      <= w_sent_nxt;
         r_btn       <= w_btn_nxt;
      end
   end

   assign busy         = w_busy;
   assign done         = (r_state == ST_DONE);
   assign btn_out      = r_btn;
   assign presses_sent = r_sent;

endmodule

// File: tb/tb_press_emitter.sv
// Directed bench for press_emitter at default timing (104-cycle press period),
// including a behavioural 16-cycle debounced press counter on btn_out.
module tb_press_emitter;

   localparam int P = 2 * 4 * 3 + 40 + 40;

   logic        clk_12m = 1'b0;
   logic        rst     = 1'b1;
   logic        start   = 1'b0;
   logic        abort   = 1'b0;
   logic [15:0] press_total = '0;
   logic        busy;
   logic        done;
   logic        btn_out;
   logic [15:0] presses_sent;

   press_emitter dut (
      .clk_12m      (clk_12m),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .press_total  (press_total),
      .busy         (busy),
      .done         (done),
      .btn_out      (btn_out),
      .presses_sent (presses_sent)
   );

   always #5 clk_12m = ~clk_12m;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int done_at  = -1;
   int done_cnt = 0;
   int btn_bad  = 0;
   int busy_bad = 0;
   int total_n  = 0;
   bit model_on = 1'b0;

   // Debounced press counter: a level must persist 16 cycles to be accepted.
   logic        db_clr = 1'b0;
   logic        db_state;
   logic [4:0]  db_cnt;
   int          db_presses;

   always @(posedge clk_12m) begin
      if (rst || db_clr) begin
         db_state   <= 1'b0;
         db_cnt     <= '0;
         db_presses <= 0;
      end else if (btn_out != db_state) begin
         if (db_cnt == 5'd15) begin
            db_state <= btn_out;
            db_cnt   <= '0;
            if (btn_out) db_presses <= db_presses + 1;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end else begin
         db_cnt <= '0;
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit exp_btn(input int c);
      int k;
      if (c < 1 || c > total_n * P) return 1'b0;
      k = (c - 1) % P;
      if (k < 12) return ((k / 3) % 2) == 0;
      if (k < 52) return 1'b1;
      if (k < 64) return (((k - 52) / 3) % 2) == 1;
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk_12m);
      #1;
      cyc++;
      if (done === 1'b1) begin
         done_cnt++;
         if (done_at < 0) done_at = cyc;
      end
      if (model_on) begin
         if (btn_out !== exp_btn(cyc)) btn_bad++;
         if (busy !== (cyc >= 1 && cyc <= total_n * P)) busy_bad++;
      end
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic start_burst(input int n, input bit model);
      cyc      = 0;
      done_at  = -1;
      done_cnt = 0;
      btn_bad  = 0;
      busy_bad = 0;
      total_n  = n;
      model_on = model;
      press_total = 16'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      // Reset, with start asserted to show reset takes priority.
      start = 1'b1;
      press_total = 16'd2;
      repeat (3) tick();
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_btn", int'(btn_out), 0);
      check("rst_sent", int'(presses_sent), 0);
      start = 1'b0;
      rst   = 1'b0;
      tick();
      check("rst_release_idle", int'(busy), 0);

      // Three presses: full waveform and done timing.
      start_burst(3, 1'b1);
      check("b3_btn_c1", int'(btn_out), 1);
      run_to(320);
      check("b3_btn_wave", btn_bad, 0);
      check("b3_busy_wave", busy_bad, 0);
      check("b3_done_at", done_at, 3 * P + 1);
      check("b3_done_cnt", done_cnt, 1);
      check("b3_sent", int'(presses_sent), 3);
      check("b3_sent_hold_idle", int'(busy) + int'(presses_sent), 3);

      // Zero presses: immediate done, never busy.
      start_burst(0, 1'b1);
      check("z_done_c1", int'(done), 1);
      check("z_busy_c1", int'(busy), 0);
      run_to(8);
      check("z_btn_wave", btn_bad, 0);
      check("z_busy_wave", busy_bad, 0);
      check("z_done_cnt", done_cnt, 1);
      check("z_sent", int'(presses_sent), 0);

      // Abort mid third press of five.
      start_burst(5, 1'b0);
      run_to(250);
      check("ab_busy_before", int'(busy), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_busy_c251", int'(busy), 0);
      check("ab_btn_c251", int'(btn_out), 0);
      check("ab_sent_c251", int'(presses_sent), 2);
      run_to(300);
      check("ab_no_done", done_cnt, 0);
      check("ab_sent_hold", int'(presses_sent), 2);

      // Start and abort together in IDLE: start dropped, count not cleared.
      press_total = 16'd2;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", int'(busy), 0);
      check("sa_sent", int'(presses_sent), 2);
      tick();
      check("sa_busy_later", int'(busy), 0);

      // Second start and new press_total mid-burst are ignored.
      start_burst(2, 1'b1);
      run_to(50);
      press_total = 16'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      run_to(230);
      check("rs_btn_wave", btn_bad, 0);
      check("rs_done_at", done_at, 2 * P + 1);
      check("rs_done_cnt", done_cnt, 1);
      check("rs_sent", int'(presses_sent), 2);

      // Debounced counter sees exactly seven presses.
      db_clr = 1'b1;
      tick();
      db_clr = 1'b0;
      start_burst(7, 1'b1);
      run_to(7 * P + 30);
      check("db_btn_wave", btn_bad, 0);
      check("db_count", db_presses, 7);
      check("db_sent", int'(presses_sent), 7);
      check("db_done_at", done_at, 7 * P + 1);

      // Reset mid-burst, then a fresh one-press burst.
      start_burst(4, 1'b0);
      run_to(150);
      rst = 1'b1;
      tick();
      check("mr_busy", int'(busy), 0);
      check("mr_btn", int'(btn_out), 0);
      check("mr_sent", int'(presses_sent), 0);
      check("mr_done", int'(done), 0);
      rst = 1'b0;
      run_to(160);
      check("mr_no_done", done_cnt, 0);
      start_burst(1, 1'b1);
      run_to(P + 10);
      check("mr_new_btn_wave", btn_bad, 0);
      check("mr_new_done_at", done_at, P + 1);
      check("mr_new_sent", int'(presses_sent), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
